// File: rtl/lsu_pkg.sv
// Shared width codes, FSM state encodings and the byte-mask helper for the load/store stage.
// No logic of its own; imported by lsu_align and lsu_pipe.
package lsu_pkg;

  localparam logic [1:0] W_BYTE  = 2'b00;
  localparam logic [1:0] W_HALF  = 2'b01;
  localparam logic [1:0] W_WORD  = 2'b10;
  localparam logic [1:0] W_DWORD = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int ALE_BIT_DEF = 6;

  function automatic logic [7:0] byte_mask(input logic [1:0] width);
    case (width)
      W_BYTE:  byte_mask = 8'h01;
      W_HALF:  byte_mask = 8'h03;
      W_WORD:  byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store stage: strobes, store shift, load shift/extend, misalignment check.
// Purely combinational (zero latency); no handshake, so no backpressure of its own.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          addr_lo_i,
  input  logic [1:0]          width_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   ldata_o,
  output logic                misalign_o,
  output logic                illegal_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] lmask;
  logic              sbit;

  assign off     = addr_lo_i[OFF_W-1:0];
  assign wstrb_o = NB'(byte_mask(width_i)) << off;
  assign wdata_o = wdata_i << {off, 3'b000};
  assign rsh     = rdata_i >> {off, 3'b000};

  // Extension by masking: the low access bits pass through, the rest take the fill bit.
  always_comb begin
    lmask = '1;
    sbit  = rsh[DATA_W-1];
    case (width_i)
      W_BYTE: begin lmask = DATA_W'(8'hFF);         sbit = rsh[7];  end
      W_HALF: begin lmask = DATA_W'(16'hFFFF);      sbit = rsh[15]; end
      W_WORD: begin lmask = DATA_W'(32'hFFFF_FFFF); sbit = rsh[31]; end
      default: ;
    endcase
  end

  assign ldata_o = (rsh & lmask) | ((signed_i && sbit) ? ~lmask : '0);

  always_comb begin
    misalign_o = 1'b0;
    case (width_i)
      W_HALF:  misalign_o = addr_lo_i[0];
      W_WORD:  misalign_o = |addr_lo_i[1:0];
      W_DWORD: misalign_o = |addr_lo_i[2:0];
      default: ;
    endcase
  end

  assign illegal_o = (width_i == W_DWORD) && (NB < 8);

endmodule

// File: rtl/lsu_pipe.sv
// Registered load/store access unit: one op at a time; accept->wb 2 cycles min, exception bypass 1 cycle.
// req_ready only in IDLE; cache request held until dc_addr_ready; stall_because_cache while the cache owns the op.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RD_W    = 5,
  parameter int EXP_W   = 7,
  parameter int ALE_BIT = ALE_BIT_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_width,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_base,
  input  logic [ADDR_W-1:0]   req_imm,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [RD_W-1:0]     req_rd,
  input  logic [EXP_W-1:0]    req_exp,
  output logic                dc_valid,
  output logic                dc_op,
  output logic [ADDR_W-1:0]   dc_addr,
  output logic [DATA_W/8-1:0] dc_wstrb,
  output logic [DATA_W-1:0]   dc_wdata,
  input  logic                dc_addr_ready,
  input  logic                dc_data_valid,
  input  logic [DATA_W-1:0]   dc_rdata,
  input  logic [EXP_W-1:0]    dc_exp,
  input  logic [ADDR_W-1:0]   dc_badv,
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic [EXP_W-1:0]    wb_exp,
  output logic [ADDR_W-1:0]   wb_badv,
  output logic                stall_because_cache
);

  localparam logic [EXP_W-1:0] ALE_VEC = EXP_W'(1) << ALE_BIT;

  logic [2:0]          state_q, state_d;
  logic                write_q, signed_q;
  logic [1:0]          width_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [RD_W-1:0]     rd_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [RD_W-1:0]     wb_rd_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic [EXP_W-1:0]    wb_exp_q;
  logic [ADDR_W-1:0]   wb_badv_q;

  logic [ADDR_W-1:0]   eff_addr;
  logic                idle, accept, ale, bypass, capture;
  logic [DATA_W/8-1:0] a_wstrb;
  logic [DATA_W-1:0]   a_wdata, a_ldata;
  logic                a_misalign, a_illegal;

  assign idle     = (state_q == ST_IDLE);
  assign eff_addr = req_base + req_imm;
  assign accept   = idle && req_valid && !flush;
  assign ale      = a_misalign || a_illegal;
  assign bypass   = (req_exp != '0) || ale;

  // In IDLE the aligner looks at the incoming op; afterwards at the latched one for load extension.
  lsu_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo_i  (idle ? eff_addr[2:0] : addr_q[2:0]),
    .width_i    (idle ? req_width : width_q),
    .signed_i   (signed_q),
    .wdata_i    (req_wdata),
    .rdata_i    (dc_rdata),
    .wstrb_o    (a_wstrb),
    .wdata_o    (a_wdata),
    .ldata_o    (a_ldata),
    .misalign_o (a_misalign),
    .illegal_o  (a_illegal)
  );

  assign capture = !flush && dc_data_valid &&
                   (((state_q == ST_REQ) && dc_addr_ready) || (state_q == ST_WAIT));

  // A flush that coincides with the response needs no DRAIN: the data is already consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = bypass ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (flush)              state_d = (dc_addr_ready && !dc_data_valid) ? ST_DRAIN : ST_IDLE;
        else if (dc_addr_ready) state_d = dc_data_valid ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (dc_data_valid) state_d = flush ? ST_IDLE : ST_RESP;
        else if (flush)    state_d = ST_DRAIN;
      end
      ST_DRAIN: if (dc_data_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Ops reaching the cache always carry req_exp == 0, so only dc_exp merges in on capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      width_q   <= W_BYTE;
      addr_q    <= '0;
      rd_q      <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_exp_q  <= '0;
      wb_badv_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q   <= req_write;
        signed_q  <= req_signed;
        width_q   <= req_width;
        addr_q    <= eff_addr;
        rd_q      <= req_rd;
        wstrb_q   <= a_wstrb;
        wdata_q   <= a_wdata;
        wb_rd_q   <= '0;
        wb_data_q <= '0;
        wb_exp_q  <= req_exp | (ale ? ALE_VEC : '0);
        wb_badv_q <= ale ? eff_addr : '0;
      end
      if (capture) begin
        wb_exp_q  <= dc_exp;
        wb_badv_q <= (dc_exp != '0) ? dc_badv : '0;
        wb_rd_q   <= (write_q || dc_exp != '0) ? '0 : rd_q;
        wb_data_q <= (write_q || dc_exp != '0) ? '0 : a_ldata;
      end
    end
  end

  assign req_ready           = idle;
  assign dc_valid            = (state_q == ST_REQ);
  assign dc_op               = write_q;
  assign dc_addr             = addr_q;
  assign dc_wstrb            = wstrb_q;
  assign dc_wdata            = wdata_q;
  assign wb_valid            = (state_q == ST_RESP) && !flush;
  assign wb_rd               = wb_rd_q;
  assign wb_data             = wb_data_q;
  assign wb_exp              = wb_exp_q;
  assign wb_badv             = wb_badv_q;
  assign stall_because_cache = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);

endmodule
